// File: rtl/maxpool2d_stream.sv
// Streaming 2x2/stride-2 signed max-pool over a raster-ordered feature map.
// Define MAXPOOL_RELU_EN to clamp negative results to zero before output.
module maxpool2d_stream #(
  parameter int unsigned rows      = 26,
  parameter int unsigned cols      = 26,
  parameter int unsigned data_size = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [data_size-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [data_size-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam int unsigned PoolRows = rows / 2;
  localparam int unsigned PoolCols = cols / 2;
  localparam int unsigned ColW     = $clog2(cols + 1);
  localparam int unsigned RowW     = $clog2(rows + 1);
  localparam int unsigned LbW      = (PoolCols > 1) ? $clog2(PoolCols) : 1;

  typedef logic [ColW-1:0] col_t;
  typedef logic [RowW-1:0] row_t;
  typedef logic signed [data_size-1:0] pix_t;

  localparam col_t ColLast     = col_t'(cols - 1);
  localparam col_t ColPairLast = col_t'(2 * PoolCols - 1);
  localparam row_t RowLast     = row_t'(rows - 1);
  localparam row_t RowPairLast = row_t'(2 * PoolRows - 1);

  col_t col_q, col_d;
  row_t row_q, row_d;
  pix_t held_q, held_d;
  pix_t out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  pix_t linebuf_q [PoolCols];

  logic           in_fire, out_fire;
  logic           col_in_pool, row_in_pool;
  logic           pair_done, lb_we, load;
  logic [LbW-1:0] lb_idx;
  pix_t           lb_rd, pair_max, pool_max, result;

  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Trailing odd column/row lie outside every window and are dropped.
  assign col_in_pool = (col_q <= ColPairLast);
  assign row_in_pool = (row_q <= RowPairLast);

  assign pair_done = in_fire && col_q[0] && col_in_pool && row_in_pool;
  assign lb_we     = pair_done && !row_q[0];
  assign load      = pair_done && row_q[0];

  assign lb_idx   = col_in_pool ? LbW'(col_q >> 1) : '0;
  assign lb_rd    = linebuf_q[lb_idx];
  assign pair_max = (in_data > held_q) ? in_data : held_q;
  assign pool_max = (lb_rd > pair_max) ? lb_rd : pair_max;

`ifdef MAXPOOL_RELU_EN
  assign result = pool_max[data_size-1] ? '0 : pool_max;
`else
  assign result = pool_max;
`endif

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    held_d = held_q;
    if (in_fire) begin
      if (!col_q[0]) begin
        held_d = in_data;
      end
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + row_t'(1);
      end else begin
        col_d = col_q + col_t'(1);
      end
    end
  end

  // A fresh result may replace one being consumed on the same edge.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_data_d  = result;
      out_valid_d = 1'b1;
      out_last_d  = (row_q == RowPairLast) && (col_q == ColPairLast);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      held_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      held_q      <= held_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Entries are always written on an even row before the odd row reads them.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= pair_max;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
